// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC, rides out
// instruction-memory wait states and applies hazard-unit stall/flush/branch controls.
module fetch_stage #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
  parameter int                     CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_f,
  input  logic                   stall_d,
  input  logic                   flush_d,
  input  logic                   PC_source,
  input  logic [PC_WIDTH-1:0]    PC_branch_e,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [PC_WIDTH-1:0]    PC_plus1_d,
  output logic                   valid_d,
  output logic [CNT_WIDTH-1:0]   mem_wait_cnt,
  output logic [CNT_WIDTH-1:0]   bubble_cnt
);

  typedef enum logic {S_RUN, S_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_plus1;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    pcp1_q;
  logic                   valid_q;
  logic [CNT_WIDTH-1:0]   wait_cnt_q, bubble_cnt_q;
  logic                   fetch_done;
  logic                   bubble_wr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign imem_req  = rst_n & ~stall_f;
  assign imem_addr = pc_q;
  assign pc_plus1  = pc_q + 1'b1;

  // A taken branch discards whatever response arrives in the same cycle.
  assign fetch_done = imem_req & imem_ready & ~PC_source;
  assign bubble_wr  = flush_d | (~stall_d & ~fetch_done);

  always_comb begin
    pc_d = pc_q;
    if (PC_source)       pc_d = PC_branch_e;
    else if (stall_f)    pc_d = pc_q;
    else if (fetch_done) pc_d = pc_plus1;
  end

  always_comb begin
    state_d = state_q;
    if (PC_source) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (imem_req && !imem_ready) state_d = S_WAIT;
        S_WAIT:  if (imem_req && imem_ready)  state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pcp1_q       <= '0;
      valid_q      <= 1'b0;
      wait_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_WAIT) wait_cnt_q <= sat_inc(wait_cnt_q);
      if (bubble_wr) begin
        instr_q      <= NOP_INSTR;
        valid_q      <= 1'b0;
        bubble_cnt_q <= sat_inc(bubble_cnt_q);
      end else if (!stall_d) begin
        instr_q <= imem_rdata;
        pcp1_q  <= pc_plus1;
        valid_q <= 1'b1;
      end
    end
  end

  assign instr_d      = instr_q;
  assign PC_plus1_d   = pcp1_q;
  assign valid_d      = valid_q;
  assign mem_wait_cnt = wait_cnt_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle model queues expected IF/ID state per
// driven cycle; entries are popped and compared after each rising edge.
module tb_fetch_stage;

  localparam int          CW   = 6;
  localparam int          WMAX = (1 << CW) - 1;
  localparam logic [15:0] NOP  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n, stall_f, stall_d, flush_d, PC_source, imem_ready;
  logic [7:0]  PC_branch_e;
  logic [15:0] imem_rdata;
  logic        imem_req, valid_d;
  logic [7:0]  imem_addr, PC_plus1_d;
  logic [15:0] instr_d;
  logic [CW-1:0] mem_wait_cnt, bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  p1;
    logic        v;
    int          wc;
    int          bc;
    logic [7:0]  pc;
  } exp_t;
  exp_t sb[$];

  logic [7:0]  m_pc    = 8'h00;
  logic        m_wait  = 1'b0;
  logic [15:0] m_instr = NOP;
  logic [7:0]  m_p1    = 8'h00;
  logic        m_v     = 1'b0;
  int          m_wc    = 0;
  int          m_bc    = 0;

  fetch_stage #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .PC_source(PC_source), .PC_branch_e(PC_branch_e),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr_d(instr_d), .PC_plus1_d(PC_plus1_d),
    .valid_d(valid_d), .mem_wait_cnt(mem_wait_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic rstn, input logic sf, input logic sd, input logic fl,
                       input logic ps, input logic [7:0] tgt, input logic rdy);
    exp_t e;
    exp_t got;
    logic done;
    logic [7:0] inc;
    @(negedge clk);
    rst_n = rstn; stall_f = sf; stall_d = sd; flush_d = fl;
    PC_source = ps; PC_branch_e = tgt; imem_ready = rdy;
    imem_rdata = rdy ? (16'h1000 + {8'h00, m_pc}) : 16'hDEAD;
    #1;
    check("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc});
    check("imem_req", {31'h0, imem_req}, {31'h0, rstn & ~sf});
    if (!rstn) begin
      m_pc = 8'h00; m_wait = 1'b0; m_instr = NOP; m_p1 = 8'h00; m_v = 1'b0;
      m_wc = 0; m_bc = 0;
    end else begin
      done = !sf && rdy && !ps;
      inc  = m_pc + 8'd1;
      if (m_wait && m_wc < WMAX) m_wc++;
      if (fl || (!sd && !done)) begin
        m_instr = NOP; m_v = 1'b0;
        if (m_bc < WMAX) m_bc++;
      end else if (!sd) begin
        m_instr = imem_rdata; m_p1 = inc; m_v = 1'b1;
      end
      if (ps)       m_wait = 1'b0;
      else if (!sf) m_wait = !rdy;
      if (ps)        m_pc = tgt;
      else if (done) m_pc = inc;
    end
    e.instr = m_instr; e.p1 = m_p1; e.v = m_v; e.wc = m_wc; e.bc = m_bc; e.pc = m_pc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("instr_d", {16'h0, instr_d}, {16'h0, got.instr});
    check("PC_plus1_d", {24'h0, PC_plus1_d}, {24'h0, got.p1});
    check("valid_d", {31'h0, valid_d}, {31'h0, got.v});
    check("mem_wait_cnt", {26'h0, mem_wait_cnt}, got.wc);
    check("bubble_cnt", {26'h0, bubble_cnt}, got.bc);
    check("pc", {24'h0, imem_addr}, {24'h0, got.pc});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 8'h00, 1);
  endtask

  initial begin
    rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    PC_source = 1'b0; PC_branch_e = 8'h00; imem_ready = 1'b1; imem_rdata = 16'h0;

    cycle(0, 0, 0, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 0, 0, 8'h00, 1);
    check("rst_valid", {31'h0, valid_d}, 32'h0);
    check("rst_instr", {16'h0, instr_d}, {16'h0, NOP});

    run(3);
    check("run_instr", {16'h0, instr_d}, 32'h1002);
    check("run_p1", {24'h0, PC_plus1_d}, 32'h3);
    check("run_bubbles", {26'h0, bubble_cnt}, 32'h0);
    run(1);

    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0, 8'h00, 0);
      check("wait_addr_hold", {24'h0, imem_addr}, 32'h4);
      check("wait_valid", {31'h0, valid_d}, 32'h0);
    end
    cycle(1, 0, 0, 0, 0, 8'h00, 1);
    check("wait_cnt", {26'h0, mem_wait_cnt}, 32'h3);
    check("wait_bubbles", {26'h0, bubble_cnt}, 32'h3);
    check("wait_instr", {16'h0, instr_d}, 32'h1004);
    check("wait_pc", {24'h0, imem_addr}, 32'h5);

    run(1);
    cycle(1, 1, 1, 0, 0, 8'h00, 1);
    check("stall_instr", {16'h0, instr_d}, 32'h1005);
    check("stall_pc", {24'h0, imem_addr}, 32'h6);
    run(1);
    check("post_stall_instr", {16'h0, instr_d}, 32'h1006);

    cycle(1, 1, 1, 1, 1, 8'h40, 1);
    check("br_pc", {24'h0, imem_addr}, 32'h40);
    check("br_valid", {31'h0, valid_d}, 32'h0);
    check("br_bubbles", {26'h0, bubble_cnt}, 32'h4);
    run(1);
    check("br_instr", {16'h0, instr_d}, 32'h1040);

    cycle(1, 0, 0, 1, 1, 8'h09, 1);
    cycle(1, 0, 0, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 0, 1, 8'h20, 1);
    check("brwait_pc", {24'h0, imem_addr}, 32'h20);
    check("brwait_nocapture", {31'h0, valid_d}, 32'h0);
    run(1);
    check("brwait_instr", {16'h0, instr_d}, 32'h1020);

    cycle(1, 1, 0, 0, 0, 8'h00, 1);
    check("stallf_bubble", {31'h0, valid_d}, 32'h0);
    cycle(1, 0, 1, 1, 0, 8'h00, 1);
    check("flush_beats_stall", {31'h0, valid_d}, 32'h0);

    cycle(1, 0, 0, 1, 1, 8'hFF, 1);
    run(1);
    check("wrap_pc", {24'h0, imem_addr}, 32'h0);
    check("wrap_p1", {24'h0, PC_plus1_d}, 32'h0);
    check("wrap_instr", {16'h0, instr_d}, 32'h10FF);

    for (int i = 0; i < 70; i++) cycle(1, 0, 0, 0, 0, 8'h00, 0);
    check("sat_wait", {26'h0, mem_wait_cnt}, WMAX);
    check("sat_bubble", {26'h0, bubble_cnt}, WMAX);

    cycle(0, 0, 0, 0, 0, 8'h00, 1);
    check("rstwait_pc", {24'h0, imem_addr}, 32'h0);
    check("rstwait_valid", {31'h0, valid_d}, 32'h0);
    check("rstwait_wcnt", {26'h0, mem_wait_cnt}, 32'h0);
    check("rstwait_instr", {16'h0, instr_d}, {16'h0, NOP});
    run(2);

    for (int i = 0; i < 300; i++) begin
      logic rps;
      rps = ($urandom_range(0, 7) == 0);
      cycle(1, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            rps | ($urandom_range(0, 9) == 0), rps,
            8'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
